// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that drives the select lines of a shared 4:1 mux.
//   req  : request vector, bit i = requester i wants the mux
//   gnt  : one-hot grant, zero when idle
//   sel  : mux select, sel[1] -> s1, sel[0] -> s0
//   busy : mux output y is valid (gnt non-zero)
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux between four requesters.
// A grant lasts until its owner drops req or has held it MAX_HOLD cycles;
// on release the next owner is picked in the same edge, starting from the
// index after the old owner, so back-to-back grants have no idle bubble.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of mux4_rr_arbiter_if (req in; gnt/sel/busy out,
//           all registered)
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..255
) (
  input  logic              clock,
  input  logic              reset,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        busy_q, busy_d;

  // Returns {found, index} of the first requester at or after p (mod 4).
  // The scan runs from farthest to nearest so the nearest hit wins.
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic       release_c;
  logic [2:0] win_c;
  logic [1:0] scan_ptr_c;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    release_c  = (!bus.req[owner_q]) || (cnt_q == MAX_HOLD_C);
    // While idle the pointer stays put; on release it moves past the owner.
    scan_ptr_c = (state_q == GRANT) ? (owner_q + 2'd1) : ptr_q;
    win_c      = pick(scan_ptr_c, bus.req);

    unique case (state_q)
      IDLE: begin
        if (win_c[2]) begin
          state_d = GRANT;
          owner_d = win_c[1:0];
          gnt_d   = 4'b0001 << win_c[1:0];
          sel_d   = win_c[1:0];
          busy_d  = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      GRANT: begin
        if (!release_c) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          ptr_d = scan_ptr_c;
          if (win_c[2]) begin
            // May re-grant the same owner when it is the sole requester.
            owner_d = win_c[1:0];
            gnt_d   = 4'b0001 << win_c[1:0];
            sel_d   = win_c[1:0];
            cnt_d   = 8'd1;
          end else begin
            // sel keeps pointing at the last owner while idle.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      owner_q <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: one instance with MAX_HOLD=4 (a) and one with
// MAX_HOLD=1 (b). A behavioural model predicts {gnt,sel,busy} for every
// edge; predictions are queued before the edge and compared after it.
module tb_mux4_rr_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, rst_b;
  mux4_rr_arbiter_if bus_a();
  mux4_rr_arbiter_if bus_b();

  mux4_rr_arbiter #(.MAX_HOLD(4)) u_dut_a (.clock(clock), .reset(rst_a), .bus(bus_a.slave));
  mux4_rr_arbiter #(.MAX_HOLD(1)) u_dut_b (.clock(clock), .reset(rst_b), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       active;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [1:0] sel;
    int         cnt;
    logic [3:0] gnt;
    logic       busy;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.active = 1'b0; m.owner = 2'd0; m.ptr = 2'd0; m.sel = 2'd0;
    m.cnt = 0; m.gnt = 4'd0; m.busy = 1'b0;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input logic [3:0] r, input int maxh);
    model_t n;
    int idx;
    n = m;
    if (m.active && r[m.owner] && m.cnt < maxh) begin
      n.cnt = m.cnt + 1;
      return n;
    end
    if (m.active) n.ptr = m.owner + 2'd1;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(n.ptr) + k) % 4;
      if (r[idx]) begin
        n.active = 1'b1; n.owner = 2'(idx); n.sel = 2'(idx);
        n.gnt = 4'(1 << idx); n.busy = 1'b1; n.cnt = 1;
        return n;
      end
    end
    n.active = 1'b0; n.gnt = 4'd0; n.busy = 1'b0; n.cnt = 0;
    return n;
  endfunction

  function automatic logic [7:0] pack_m(input model_t m);
    return {1'b0, m.gnt, m.sel, m.busy};
  endfunction

  model_t     m_a, m_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  // One clock: predict, push, let the edge happen, pop and compare.
  task automatic cycle();
    logic [7:0] ea, eb;
    m_a = rst_a ? model_reset() : step(m_a, bus_a.req, 4);
    m_b = rst_b ? model_reset() : step(m_b, bus_b.req, 1);
    q_a.push_back(pack_m(m_a));
    q_b.push_back(pack_m(m_b));
    @(posedge clock);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("sb_a", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, ea);
    chk("sb_b", {1'b0, bus_b.gnt, bus_b.sel, bus_b.busy}, eb);
    $display("t=%0t req_a=%b gnt_a=%b sel_a=%b busy_a=%b | req_b=%b gnt_b=%b sel_b=%b busy_b=%b",
             $time, bus_a.req, bus_a.gnt, bus_a.sel, bus_a.busy,
             bus_b.req, bus_b.gnt, bus_b.sel, bus_b.busy);
  endtask

  task automatic set_req(input logic [3:0] r);
    bus_a.req = r;
    bus_b.req = r;
  endtask

  initial begin
    // Reset held with all requesters active.
    rst_a = 1'b1; rst_b = 1'b1;
    set_req(4'b1111);
    m_a = model_reset(); m_b = model_reset();
    #2;
    chk("rst_a_async", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, 8'h00);
    @(posedge clock); @(posedge clock); #1;
    chk("rst_a_held", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, 8'h00);
    chk("rst_b_held", {1'b0, bus_b.gnt, bus_b.sel, bus_b.busy}, 8'h00);
    rst_a = 1'b0; rst_b = 1'b0;

    // First edge after reset grants requester 0; then full rotation.
    cycle();
    chk("first_grant", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, {1'b0, 4'b0001, 2'b00, 1'b1});
    for (int i = 1; i <= 16; i++) begin
      cycle();
      chk("rot_sel", {6'd0, bus_a.sel}, 8'((i / 4) % 4));
      chk("rot_busy", {7'd0, bus_a.busy}, 8'd1);
    end

    // Drop everything: owner 0 releases, idle, sel holds 00.
    set_req(4'b0000);
    cycle();
    chk("idle_a", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, 8'h00);

    // Sole requester 2 for 10 cycles, re-granted without a gap.
    set_req(4'b0100);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("sole_a", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, {1'b0, 4'b0100, 2'b10, 1'b1});
    end
    set_req(4'b0000);
    cycle();
    chk("idle_sel_hold", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, {1'b0, 4'b0000, 2'b10, 1'b0});

    // Early release: requester 1 for 2 cycles, requester 3 waiting.
    set_req(4'b0010);
    cycle();
    set_req(4'b1010);
    cycle();
    chk("early_hold", {4'd0, bus_a.gnt}, 8'b0000_0010);
    set_req(4'b1000);
    cycle();
    chk("early_next", {4'd0, bus_a.gnt}, 8'b0000_1000);
    set_req(4'b1001);
    for (int i = 0; i < 3; i++) cycle();
    chk("hold_max", {4'd0, bus_a.gnt}, 8'b0000_1000);
    cycle();
    chk("ptr_wrap0", {4'd0, bus_a.gnt}, 8'b0000_0001);

    // Owner drops with nobody else: idle, then a fresh request.
    set_req(4'b0000);
    cycle();
    chk("ret_idle", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, 8'h00);
    cycle();
    cycle();
    set_req(4'b0001);
    cycle();
    chk("regrant", {1'b0, bus_a.gnt, bus_a.sel, bus_a.busy}, {1'b0, 4'b0001, 2'b00, 1'b1});

    // Mid-grant asynchronous reset on the MAX_HOLD=1 instance.
    set_req(4'b1010);
    cycle();
    cycle();
    chk("b_busy_pre", {7'd0, bus_b.busy}, 8'd1);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_async_rst", {1'b0, bus_b.gnt, bus_b.sel, bus_b.busy}, 8'h00);
    cycle();
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("b_alt", {4'd0, bus_b.gnt}, (i % 2 == 0) ? 8'b0000_0010 : 8'b0000_1000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      set_req(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) bus_b.req = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 mux between four requesters.
- Grants one requester at a time and drives the mux select lines s1/s0 via sel[1:0].
- Flags when the mux output is valid, and limits each grant to MAX_HOLD consecutive cycles for fairness.
- Sits directly in front of the 4:1 mux: sel[1] drives s1 and sel[0] drives s0. Mux inputs a, b, c, d correspond to requesters 0, 1, 2, 3.

Parameters:
- MAX_HOLD, default 4: maximum consecutive cycles one requester keeps the grant. Legal range is 1 to 255.

Ports:
- clock   input   1   system clock; all state updates on the rising edge.
- reset   input   1   asynchronous, active-high reset.
- req     input   4   request vector; req[i] high means requester i wants the mux.
- gnt     output  4   registered one-hot grant; all zeros when idle.
- sel     output  2   registered mux select; sel[1] goes to s1 and sel[0] goes to s0.
- busy    output  1   registered; high whenever gnt is non-zero, meaning the mux output y is valid.

Behaviour:
- Reset is asynchronous and active-high and takes effect immediately, including mid-grant. Reset values:
  - gnt=4'b0000, sel=2'b00, busy=0.
  - Internal state=IDLE, rr pointer ptr=0, hold counter cnt=0.
- Internal state:
  - FSM with two states: IDLE and GRANT.
  - ptr is 2 bits: the highest-priority index for the next arbitration.
  - cnt is 8 bits, counts 1..MAX_HOLD.
  - owner is the 2-bit index of the current grant.
- Arbitration function: starting at index ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req high wins.
- IDLE:
  - If req==0: stay IDLE; gnt, busy and ptr are unchanged; sel holds its last value.
  - If req!=0: go to GRANT.
    - owner = winner; gnt = one-hot(winner); sel = winner; busy=1; cnt=1.
    - Latency: req sampled high at edge N gives gnt/sel/busy valid after edge N.
- GRANT, release condition: req[owner]==0 OR cnt==MAX_HOLD, both sampled at the edge.
- GRANT, no release:
  - Stay in GRANT with gnt/sel unchanged.
  - cnt increments by 1 (never exceeds MAX_HOLD).
- GRANT, on release:
  - ptr = owner+1 (mod 4, 2-bit wrap).
  - Re-arbitrate in the same edge using the new ptr and the current req.
  - If a winner exists: stay in GRANT, load the new owner/gnt/sel, cnt=1. There is no idle bubble between back-to-back grants.
  - A winner exists for the old owner itself when it is the only requester and it is still requesting at MAX_HOLD. It is re-granted with gnt unchanged and cnt reloaded to 1.
  - If no winner: go to IDLE; gnt=0, busy=0, cnt=0; sel holds the old owner.
- Simultaneous events:
  - If the owner drops req in the same cycle that cnt==MAX_HOLD, it is treated as a single release.
  - New requests arriving during a grant are not considered until release.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - When busy==1, sel == index of the set bit of gnt.
  - A requester that holds req high is granted within 3*MAX_HOLD+1 cycles.
- MAX_HOLD=1: the grant rotates every cycle among active requesters.

Test Plan:
- Reset behaviour: assert reset with req=4'b1111 held, then release. Required: gnt=0000, sel=00, busy=0 during reset. After the first edge post-reset: gnt=0001, sel=00, busy=1.
- Sole requester: req=4'b0100 held for 10 cycles, MAX_HOLD=4. Required: gnt=0100, sel=10 and busy=1 for all 10 cycles, with no gap at the 4-cycle re-grant.
- All requesters held: req=4'b1111, MAX_HOLD=4. Required: sel sequence 00 x4, 01 x4, 10 x4, 11 x4, then 00, with no idle cycle between grants.
- Early release: req[1] high for 2 cycles then low, while req[3] is high throughout. Required: gnt=0010 for 2 cycles, then 1000 on the very next cycle, and ptr then favours index 0 (next requester after 3).
- Return to idle: the owner drops req with req=0 elsewhere. Required: gnt=0000 and busy=0 the next cycle, sel holds the last index. A new req=0001 later gives gnt=0001 one edge after it is sampled.
- Mid-grant reset, with MAX_HOLD=1: assert reset asynchronously between edges during a grant. Required: gnt=0000 and busy=0 immediately, without waiting for a clock edge. Then, after reset is released with req=1010, gnt alternates 0010 and 1000 every cycle.
